// File: rtl/trdb_packet_scheduler.sv
// ============================================================================
// Module   : trdb_packet_scheduler
// Brief    : In-order packet request FIFO with overflow drop and sync injection
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package trdb_pkg;
    typedef enum logic [1:0] {
        F_OPT_EXT    = 2'b00,
        F_DIFF_DELTA = 2'b01,
        F_ADDR_ONLY  = 2'b10,
        F_SYNC       = 2'b11
    } trdb_format_e;

    typedef enum logic [1:0] {
        SF_START   = 2'b00,
        SF_TRAP    = 2'b01,
        SF_CONTEXT = 2'b10,
        SF_SUPPORT = 2'b11
    } trdb_f_sync_subformat_e;

    typedef enum logic [1:0] {
        NO_CHANGE  = 2'b00,
        ENDED_REP  = 2'b01,
        TRACE_LOST = 2'b10,
        ENDED_NTR  = 2'b11
    } qual_status_e;
endpackage

module trdb_packet_scheduler
    import trdb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        valid_i,
    input  trdb_format_e                packet_format_i,
    input  trdb_f_sync_subformat_e      packet_f_sync_subformat_i,
    input  logic                        thaddr_i,
    input  logic                        cause_mux_i,
    input  logic                        tval_mux_i,
    input  qual_status_e                qual_status_i,
    input  logic                        ready_i,
    output logic                        valid_o,
    output trdb_format_e                packet_format_o,
    output trdb_f_sync_subformat_e      packet_f_sync_subformat_o,
    output logic                        thaddr_o,
    output logic                        cause_mux_o,
    output logic                        tval_mux_o,
    output qual_status_e                qual_status_o,
    output logic                        resync_req_o,
    output logic                        packets_lost_o,
    output logic [CNT_W-1:0]            lost_cnt_o,
    output logic [$clog2(DEPTH):0]      level_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int ENT_W = 9;
    localparam logic [LVL_W-1:0] c_full = LVL_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_NORMAL = 2'b00,
        ST_LOST   = 2'b01,
        ST_INJECT = 2'b10
    } state_t;

    state_t               r_state;
    logic [ENT_W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [LVL_W-1:0]     r_level;
    logic [CNT_W-1:0]     r_lost_cnt;
    logic                 r_packets_lost;
    logic                 r_resync;

    logic                 w_nonempty;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_drop;
    logic [ENT_W-1:0]     w_entry;
    logic [ENT_W-1:0]     w_head;

    assign w_nonempty = (r_level != '0);
    // The injected packet never coexists with FIFO content: INJECT is only entered empty.
    assign w_pop      = w_nonempty && ready_i && (r_state != ST_INJECT);
    assign w_push     = valid_i && (r_state == ST_NORMAL) && ((r_level < c_full) || w_pop);
    assign w_drop     = valid_i && !w_push;
    assign w_entry    = {packet_format_i, packet_f_sync_subformat_i, thaddr_i,
                         cause_mux_i, tval_mux_i, qual_status_i};
    assign w_head     = r_mem[r_rd_ptr];

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state        <= ST_NORMAL;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_level        <= '0;
            r_lost_cnt     <= '0;
            r_packets_lost <= 1'b0;
            r_resync       <= 1'b0;
        end else begin
            r_resync <= 1'b0;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + LVL_W'(1);
            end else if (!w_push && w_pop) begin
                r_level <= r_level - LVL_W'(1);
            end
            if (w_drop && (r_lost_cnt != '1)) begin
                r_lost_cnt <= r_lost_cnt + CNT_W'(1);
            end
            case (r_state)
                ST_NORMAL: begin
                    if (w_drop) begin
                        r_packets_lost <= 1'b1;
                        r_state        <= ST_LOST;
                    end
                end
                ST_LOST: begin
                    if (r_level == '0) begin
                        r_state <= ST_INJECT;
                    end
                end
                ST_INJECT: begin
                    if (ready_i) begin
                        r_packets_lost <= 1'b0;
                        r_resync       <= 1'b1;
                        r_state        <= ST_NORMAL;
                    end
                end
                default: r_state <= ST_NORMAL;
            endcase
        end
    end

    always_comb begin
        valid_o                   = 1'b0;
        packet_format_o           = F_OPT_EXT;
        packet_f_sync_subformat_o = SF_START;
        thaddr_o                  = 1'b0;
        cause_mux_o               = 1'b0;
        tval_mux_o                = 1'b0;
        qual_status_o             = NO_CHANGE;
        if (r_state == ST_INJECT) begin
            valid_o                   = 1'b1;
            packet_format_o           = F_SYNC;
            packet_f_sync_subformat_o = SF_SUPPORT;
            qual_status_o             = TRACE_LOST;
        end else if (w_nonempty) begin
            valid_o                   = 1'b1;
            packet_format_o           = trdb_format_e'(w_head[8:7]);
            packet_f_sync_subformat_o = trdb_f_sync_subformat_e'(w_head[6:5]);
            thaddr_o                  = w_head[4];
            cause_mux_o               = w_head[3];
            tval_mux_o                = w_head[2];
            qual_status_o             = qual_status_e'(w_head[1:0]);
        end
    end

    assign resync_req_o   = r_resync;
    assign packets_lost_o = r_packets_lost;
    assign lost_cnt_o     = r_lost_cnt;
    assign level_o        = r_level;

endmodule

`default_nettype wire
